// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with IDLE/RUN/EXPIRED control and terminal-count pulse.
//
// Ports:
//   clock      - sole clock, rising edge
//   reset      - asynchronous active-high reset
//   load       - load loadValue (has priority over enable in every state)
//   loadValue  - start value of the countdown
//   enable     - decrement qualifier, only honoured in RUN
//   count      - registered counter value
//   zero       - combinational, high when count == 0
//   done       - registered one-cycle pulse after the 1 -> terminal step
//   busy       - high while in RUN
//
// Build option: define COUNTDOWN_AUTO_RELOAD_EN to reload the start value at
// terminal count and stay in RUN (periodic done); the port list is unchanged.
module countdown_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             done,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            done_q   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            done_q   <= done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        done_d   = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        if (load) begin
            // A zero start value parks the timer in IDLE rather than running it.
            count_d  = loadValue;
            state_d  = (loadValue != '0) ? RUN : IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_d = loadValue;
`endif
        end else if (state_q == RUN && enable) begin
            if (count_q == ONE) begin
                done_d  = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                count_d = reload_q;
`else
                count_d = '0;
                state_d = EXPIRED;
`endif
            end else if (count_q != '0) begin
                // The zero guard makes an all-ones wrap impossible.
                count_d = count_q - ONE;
            end
        end
    end

    always_comb begin
        count = count_q;
        zero  = (count_q == '0);
        done  = done_q;
        busy  = (state_q == RUN);
    end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench for countdown_timer with directed vectors.
module tb_countdown_timer;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] loadValue = '0;
    logic       enable = 1'b0;
    logic [3:0] count;
    logic       zero, done, busy;

    typedef struct packed {
        logic [3:0] c;
        logic       z;
        logic       d;
        logic       b;
    } obs_t;

    obs_t q[$];
    obs_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    countdown_timer #(.WIDTH(4)) dut (
        .clock(clock), .reset(reset), .load(load), .loadValue(loadValue),
        .enable(enable), .count(count), .zero(zero), .done(done), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic void chk(string nm, obs_t exp_v);
        obs_t act;
        act = '{count, zero, done, busy};
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got count=%0d zero=%b done=%b busy=%b, want count=%0d zero=%b done=%b busy=%b",
                     nm, act.c, act.z, act.d, act.b, exp_v.c, exp_v.z, exp_v.d, exp_v.b);
        end
    endfunction

    always @(posedge clock) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            cyc++;
            chk($sformatf("cycle%0d", cyc), e);
        end
    end

    task automatic step(input logic ld, input logic [3:0] lv, input logic en,
                        input logic [3:0] c, input logic d, input logic b);
        @(negedge clock);
        load = ld;
        loadValue = lv;
        enable = en;
        q.push_back('{c, c == 4'd0, d, b});
    endtask

    initial begin
        #3;
        chk("reset_state", '{4'd0, 1'b1, 1'b0, 1'b0});
        @(negedge clock);
        reset = 1'b0;
`ifndef COUNTDOWN_AUTO_RELOAD_EN
        // load 3, continuous enable: 3,2,1,0 with done on the first 0
        step(1, 3, 1, 3, 0, 1);
        step(0, 0, 1, 2, 0, 1);
        step(0, 0, 1, 1, 0, 1);
        step(0, 0, 1, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // enable toggled: 3,2,2,1,1,0 and a single done
        step(1, 3, 0, 3, 0, 1);
        step(0, 0, 1, 2, 0, 1);
        step(0, 0, 0, 2, 0, 1);
        step(0, 0, 1, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0);
`else
        // auto reload: period of two enabled cycles, busy stays high
        step(1, 2, 1, 2, 0, 1);
        step(0, 0, 1, 1, 0, 1);
        step(0, 0, 1, 2, 1, 1);
        step(0, 0, 1, 1, 0, 1);
        step(0, 0, 1, 2, 1, 1);
        step(0, 0, 1, 1, 0, 1);
        step(0, 0, 1, 2, 1, 1);
        step(0, 0, 1, 1, 0, 1);
        step(0, 0, 1, 2, 1, 1);
        step(0, 0, 0, 2, 0, 1);
`endif
        // load coincident with terminal count wins, no done
        step(1, 2, 0, 2, 0, 1);
        step(0, 0, 1, 1, 0, 1);
        step(1, 5, 1, 5, 0, 1);
        step(0, 0, 0, 5, 0, 1);
        // load of zero parks in IDLE; enable ignored
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        // asynchronous reset between edges at count 2
        step(1, 4, 0, 4, 0, 1);
        step(0, 0, 1, 3, 0, 1);
        step(0, 0, 1, 2, 0, 1);
        step(0, 0, 0, 2, 0, 1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", '{4'd0, 1'b1, 1'b0, 1'b0});
        #1;
        reset = 1'b0;
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
